// File: rtl/uart_rx_frame.sv
// Oversampling UART receiver: 2-FF synchroniser, 3-sample majority vote, 5..9 data bits,
// 1/2 stop bits, valid/ready output. Define UART_RX_PARITY_EN to add a parity bit after the data.
module uart_rx_frame #(
  parameter int CLK_RATE    = 100000000,
  parameter int BAUD_RATE   = 115200,
  parameter int WORD_LENGTH = 8,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_ODD  = 0
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx_serial,
  input  logic                   i_rx_ready,
  output logic                   o_rx_valid,
  output logic [WORD_LENGTH-1:0] o_rx_byte,
  output logic                   o_frame_err,
  output logic                   o_parity_err,
  output logic                   o_overrun,
  output logic                   o_busy
);

  localparam int CPB = CLK_RATE / BAUD_RATE;
  localparam int MID = CPB / 2;
  localparam int CW  = $clog2(CPB);

  if (CPB < 8 || WORD_LENGTH < 5 || WORD_LENGTH > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_frame: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_meta_d;
  logic                   rx_s_q, rx_s_d;
  logic                   rx_prev_q, rx_prev_d;
  logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic [1:0]             samp_q, samp_d;
  logic [WORD_LENGTH-1:0] shreg_q, shreg_d;
  logic                   fe_pend_q, fe_pend_d;
  logic                   valid_q, valid_d;
  logic [WORD_LENGTH-1:0] byte_q, byte_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
  logic                   busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  localparam logic PODD = (PARITY_ODD != 0);
  logic                   pe_pend_q, pe_pend_d;
  logic                   parity_err_q, parity_err_d;
`endif

  logic vote, at_vote, bit_end, commit, commit_fe;

  assign vote    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign at_vote = (clk_cnt_q == CW'(MID + 1));
  assign bit_end = (clk_cnt_q == CW'(CPB - 1));

  always_comb begin
    state_d     = state_q;
    rx_meta_d   = i_rx_serial;
    rx_s_d      = rx_meta_q;
    rx_prev_d   = rx_s_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    samp_d      = samp_q;
    shreg_d     = shreg_q;
    fe_pend_d   = fe_pend_q;
    valid_d     = valid_q;
    byte_d      = byte_q;
    frame_err_d = frame_err_q;
    overrun_d   = 1'b0;
    commit      = 1'b0;
    commit_fe   = fe_pend_q;
`ifdef UART_RX_PARITY_EN
    pe_pend_d    = pe_pend_q;
    parity_err_d = parity_err_q;
`endif

    if (state_q != S_IDLE) begin
      clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
      if (clk_cnt_q == CW'(MID - 1)) samp_d[0] = rx_s_q;
      if (clk_cnt_q == CW'(MID))     samp_d[1] = rx_s_q;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d   = S_START;
          clk_cnt_d = '0;
          fe_pend_d = 1'b0;
`ifdef UART_RX_PARITY_EN
          pe_pend_d = 1'b0;
`endif
        end
      end
      S_START: begin
        if (at_vote && vote) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        if (at_vote) shreg_d = {vote, shreg_q[WORD_LENGTH-1:1]};
        if (bit_end) begin
          if (bit_idx_q == 4'(WORD_LENGTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (at_vote && (vote != ((^shreg_q) ^ PODD))) pe_pend_d = 1'b1;
        if (bit_end) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (at_vote) begin
          commit_fe = fe_pend_q | ~vote;
          fe_pend_d = commit_fe;
          // Leave mid-bit on the last stop vote so a back-to-back start edge is seen.
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (bit_end) begin
          stop_idx_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (commit) begin
      if (!valid_q || i_rx_ready) begin
        valid_d     = 1'b1;
        byte_d      = shreg_q;
        frame_err_d = commit_fe;
`ifdef UART_RX_PARITY_EN
        parity_err_d = pe_pend_q;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && i_rx_ready) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      stop_idx_q  <= 1'b0;
      samp_q      <= 2'b11;
      shreg_q     <= '0;
      fe_pend_q   <= 1'b0;
      valid_q     <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pe_pend_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      rx_prev_q   <= rx_prev_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      samp_q      <= samp_d;
      shreg_q     <= shreg_d;
      fe_pend_q   <= fe_pend_d;
      valid_q     <= valid_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      pe_pend_q    <= pe_pend_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign o_rx_valid  = valid_q;
  assign o_rx_byte   = byte_q;
  assign o_frame_err = frame_err_q;
  assign o_overrun   = overrun_q;
  assign o_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_err_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: an 8-bit/1-stop receiver and a 7-bit/2-stop receiver,
// each on its own serial line; expected words are queued at send time and popped on handshake.
module tb_uart_rx_frame;
  localparam int CLK_RATE = 100000000;
  localparam int BAUD     = 1000000;
  localparam int CPB      = CLK_RATE / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic gclk = 1'b0;
  logic rst  = 1'b1;
  always #5 gclk = ~gclk;

  logic       rx0 = 1'b1, rdy0 = 1'b1;
  logic       v0, fe0, pe0, ov0, busy0;
  logic [7:0] b0;
  logic       rx1 = 1'b1, rdy1 = 1'b1;
  logic       v1, fe1, pe1, ov1, busy1;
  logic [6:0] b1;

  uart_rx_frame #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .WORD_LENGTH(8), .STOP_BITS(1),
                  .PARITY_ODD(0)) u_dut0 (
    .i_clk(gclk), .i_rst(rst), .i_rx_serial(rx0), .i_rx_ready(rdy0), .o_rx_valid(v0),
    .o_rx_byte(b0), .o_frame_err(fe0), .o_parity_err(pe0), .o_overrun(ov0), .o_busy(busy0));

  uart_rx_frame #(.CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD), .WORD_LENGTH(7), .STOP_BITS(2),
                  .PARITY_ODD(0)) u_dut1 (
    .i_clk(gclk), .i_rst(rst), .i_rx_serial(rx1), .i_rx_ready(rdy1), .o_rx_valid(v1),
    .o_rx_byte(b1), .o_frame_err(fe1), .o_parity_err(pe1), .o_overrun(ov1), .o_busy(busy1));

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int   checks = 0, errors = 0;
  int   ovr0 = 0, ovr1 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge gclk) begin
    if (ov0) ovr0++;
    if (ov1) ovr1++;
    if (v0 && rdy0) begin
      if (q0.size() == 0) chk("dut0_unexpected_word", 1, 0);
      else begin
        e0 = q0.pop_front();
        chk("dut0_data", b0, e0.data);
        chk("dut0_frame_err", fe0, e0.fe);
        chk("dut0_parity_err", pe0, e0.pe);
      end
    end
    if (v1 && rdy1) begin
      if (q1.size() == 0) chk("dut1_unexpected_word", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("dut1_data", b1, e1.data);
        chk("dut1_frame_err", fe1, e1.fe);
        chk("dut1_parity_err", pe1, e1.pe);
      end
    end
  end

  task automatic line_bit(input int which, input logic val);
    if (which == 0) rx0 = val;
    else rx1 = val;
    repeat (CPB) @(negedge gclk);
  endtask

  task automatic send_word(input int which, input logic [8:0] data, input bit flip_par,
                           input bit stop_low, input bit expect_it);
    int         nb, ns;
    logic [8:0] m;
    exp_t       e;
    nb = (which == 0) ? 8 : 7;
    ns = (which == 0) ? 1 : 2;
    m  = '0;
    for (int i = 0; i < nb; i++) m[i] = data[i];
    e.data = m;
    e.fe   = stop_low;
    e.pe   = PAR_EN & flip_par;
    if (expect_it) begin
      if (which == 0) q0.push_back(e);
      else q1.push_back(e);
    end
    line_bit(which, 1'b0);
    for (int i = 0; i < nb; i++) line_bit(which, m[i]);
`ifdef UART_RX_PARITY_EN
    line_bit(which, (^m) ^ flip_par);
`endif
    for (int i = 0; i < ns; i++) line_bit(which, ~stop_low);
    if (stop_low) line_bit(which, 1'b1);
  endtask

  task automatic wait_drain(input int which, input int budget);
    int n;
    n = 0;
    while (((which == 0) ? q0.size() : q1.size()) != 0 && n < budget) begin
      @(negedge gclk);
      n++;
    end
    chk(which == 0 ? "dut0_drain" : "dut1_drain", (which == 0) ? q0.size() : q1.size(), 0);
    @(negedge gclk);
  endtask

  int ovb;

  initial begin
    rst = 1'b1;
    repeat (4) @(negedge gclk);
    chk("rst_valid0", v0, 0);
    chk("rst_byte0", b0, 0);
    chk("rst_fe0", fe0, 0);
    chk("rst_pe0", pe0, 0);
    chk("rst_ovr0", ov0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_valid1", v1, 0);
    chk("rst_busy1", busy1, 0);
    rst = 1'b0;
    repeat (10) @(negedge gclk);

    // single word, consumer always ready: one-cycle valid
    send_word(0, 9'h37, 0, 0, 1);
    wait_drain(0, 200);
    chk("t1_valid_one_cycle", v0, 0);

`ifdef UART_RX_PARITY_EN
    send_word(0, 9'h37, 0, 0, 1);
    send_word(0, 9'h37, 1, 0, 1);
    wait_drain(0, 200);
`endif

    // 200 ns glitch: start rejected at the mid-bit vote
    rx0 = 1'b0;
    repeat (20) @(negedge gclk);
    rx0 = 1'b1;
    repeat (5) @(negedge gclk);
    chk("glitch_busy", busy0, 1);
    repeat (CPB / 2 + 10) @(negedge gclk);
    chk("glitch_idle", busy0, 0);
    chk("glitch_no_valid", v0, 0);
    send_word(0, 9'hA5, 0, 0, 1);
    wait_drain(0, 200);

    // line break: all-low frame delivered with a frame error
    send_word(0, 9'h00, 0, 1, 1);
    wait_drain(0, 200);

    // overrun: consumer stalled across two back-to-back words
    ovb  = ovr0;
    rdy0 = 1'b0;
    send_word(0, 9'h11, 0, 0, 1);
    send_word(0, 9'h22, 0, 0, 0);
    repeat (10) @(negedge gclk);
    chk("ovr_held_valid", v0, 1);
    chk("ovr_held_byte", b0, 8'h11);
    chk("ovr_pulses", ovr0 - ovb, 1);
    rdy0 = 1'b1;
    wait_drain(0, 50);
    chk("ovr_pulses_after", ovr0 - ovb, 1);

    // reset during data bit 4 of 0x5A
    line_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) line_bit(0, (i == 1 || i == 3) ? 1'b1 : 1'b0);
    rx0 = 1'b1;
    repeat (CPB / 2) @(negedge gclk);
    chk("mid_busy0", busy0, 1);
    rst = 1'b1;
    @(negedge gclk);
    chk("midrst_valid0", v0, 0);
    chk("midrst_byte0", b0, 0);
    chk("midrst_fe0", fe0, 0);
    chk("midrst_busy0", busy0, 0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge gclk);
    send_word(0, 9'h5A, 0, 0, 1);
    wait_drain(0, 200);

    // 7-bit, 2-stop receiver
    send_word(1, 9'h3C, 0, 0, 1);
    wait_drain(1, 200);
    line_bit(1, 1'b0);
    for (int i = 0; i < 4; i++) line_bit(1, (i >= 2) ? 1'b1 : 1'b0);
    rx1 = 1'b1;
    repeat (CPB / 2) @(negedge gclk);
    chk("mid_busy1", busy1, 1);
    rst = 1'b1;
    @(negedge gclk);
    chk("midrst_valid1", v1, 0);
    chk("midrst_byte1", b1, 0);
    chk("midrst_busy1", busy1, 0);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge gclk);
    send_word(1, 9'h3C, 0, 0, 1);
    send_word(1, 9'h5B, 0, 1, 1);
    wait_drain(1, 300);

    for (int k = 0; k < 3; k++) begin
      send_word(0, 9'($urandom_range(0, 255)), 0, 0, 1);
      send_word(1, 9'($urandom_range(0, 127)), 0, 0, 1);
    end
    wait_drain(0, 200);
    wait_drain(1, 200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
